fp_add_sub: RTL and testbench
=============================

# fp_add_sub

IEEE-754 floating-point adder/subtractor supporting binary64 and binary32 operands, selected per operation. It sits in the datapath FPU as the add/sub execution unit. It computes A+B or A−B with round-to-nearest-even and flush-to-zero subnormal handling. Result and overflow/underflow flags are registered once.

## Interface
- No parameters; format widths come from the shared package.
- in_clk  input  1  clock. All state updates on the rising edge.
- in_rst  input  1  reset. Asynchronous, active-high.
- in_numA  input  64  operand A. For binary32 only bits [31:0] are used.
- in_numB  input  64  operand B. Same packing as in_numA.
- in_addsub  input  1  0 = A+B, 1 = A−B.
- in_fmt  input  1  1 = binary64, 0 = binary32.
- out_result  output  64  rounded result. For binary32, the value is in [31:0] and [63:32] are 0.
- out_flag_OF  output  1  overflow flag for the registered result.
- out_flag_UF  output  1  underflow flag for the registered result.

## Operation
- Effective B sign = B.sign XOR in_addsub.
- Unpack:
  - Exponent 0 means zero; subnormal inputs are flushed to ±0.
  - Exponent all-ones with mantissa 0 means ±Inf; with mantissa ≠0 it means NaN.
  - Normal numbers get the hidden 1 prepended.
- Specials, checked in priority order:
  - Any NaN, or +Inf + (−Inf) after effective sign, gives the canonical quiet NaN: 7FF8000000000000 (binary64) or 0000_0000_7FC00000 (binary32).
  - Otherwise any Inf gives that Inf.
  - A zero operand gives the other operand (post-flush), with its effective sign.
  - Both zero gives −0 only if both effective signs are negative, else +0.
- Datapath:
  - Swap so the larger magnitude comes first.
  - Align the smaller operand by the exponent difference, keeping guard, round and sticky bits. A shift ≥ mantissa width+3 collapses the operand into sticky.
  - Add or subtract the mantissas.
  - Normalize with a leading-zero count.
  - Round to nearest, ties to even. Re-normalize on mantissa carry-out.
- Exact zero from subtraction gives +0.
- Overflow: if the final exponent is ≥ all-ones, the result is ±Inf and OF=1.
- Underflow: if a nonzero result has exponent < 1 (would be subnormal), the result is ±0 with the result sign and UF=1.
- OF/UF are 0 for special-case results.

## Timing
- One-cycle latency: inputs sampled at edge N appear on out_* after edge N; the arithmetic between is purely combinational.
- No handshake. A new operation can be issued every cycle.
- Reset: out_result=0, out_flag_OF=0, out_flag_UF=0.
- Reset asserted mid-operation discards the in-flight result. Outputs stay 0 until the first edge after deassertion.
- in_fmt and in_addsub are sampled on the same edge as the operands.

## Configuration
- FP_ADDSUB_FMT32_EN
  - Defined: binary32 mode is supported as described.
  - Undefined: in_fmt is ignored, every operation is binary64, and the binary32 pack/unpack logic is removed.

## Structure
- Package fp_addsub_pkg holds:
  - per-format exponent/mantissa widths and biases;
  - canonical quiet-NaN constants;
  - the unpacked-operand struct typedef {sign, exp, mant, is_zero, is_inf, is_nan}.
- One sub-module: fp_lzc, a 56-bit leading-zero counter used by normalization.
- Unpack, align, add, round and pack stay in the top module.

## Test plan
- fmt=1, A=3FF0000000000000, B=4000000000000000:
  - add → 4008000000000000, flags 0;
  - sub → BFF0000000000000.
- fmt=1, A=B=3FF0000000000000, sub → 0000000000000000 (+0).
- fmt=1, A=B=7FEFFFFFFFFFFFFF, add → 7FF0000000000000, OF=1.
- fmt=0, A=FFFFFFFF3F800000, B=0000000040000000, add → 0000000040400000 (upper input bits ignored).
- fmt=1, A=B=7FF0000000000000, sub → 7FF8000000000000. Then A=0010000000000001, B=0010000000000000, sub → 0000000000000000, UF=1.
- Reset asserted after issuing the 1.0+2.0 op → outputs 0 on the next cycle. After release, the next op's result appears one edge after sampling.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// fp_addsub_pkg: format widths, biases, quiet-NaN constants and unpacked operand type
package fp_addsub_pkg;
  localparam int E64 = 11;
  localparam int M64 = 52;
  localparam int BIAS64 = (1 << (E64 - 1)) - 1;
  localparam int E32 = 8;
  localparam int M32 = 23;
  localparam int BIAS32 = (1 << (E32 - 1)) - 1;
  localparam int PAD32 = M64 - M32;
  localparam logic [E64-1:0] EMAX64 = 11'(2 * BIAS64 + 1);
  localparam logic [E64-1:0] EMAX32 = 11'(2 * BIAS32 + 1);
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] QNAN32 = 64'h0000_0000_7FC0_0000;
  typedef struct packed {
    logic           sign;
    logic [E64-1:0] exp;
    logic [M64:0]   mant;
    logic           is_zero;
    logic           is_inf;
    logic           is_nan;
  } operand_t;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: 56-bit leading-zero counter for post-add normalization
module fp_lzc (
  input  logic [55:0] d,
  output logic [5:0]  cnt
);
  // Scan upward so the highest set bit determines the count
  always_comb begin
    cnt = 6'd56;
    for (int i = 0; i < 56; i++) cnt = d[i] ? 6'(55 - i) : cnt;
  end
endmodule

// File: rtl/fp_add_sub.sv
// fp_add_sub: binary64/binary32 RNE adder-subtractor with flush-to-zero; binary32 mode under FP_ADDSUB_FMT32_EN
module fp_add_sub
  import fp_addsub_pkg::*;
(
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [63:0] in_numA,
  input  logic [63:0] in_numB,
  input  logic        in_addsub,
  input  logic        in_fmt,
  output logic [63:0] out_result,
  output logic        out_flag_OF,
  output logic        out_flag_UF
);
  logic f64;
`ifdef FP_ADDSUB_FMT32_EN
  assign f64 = in_fmt;
`else
  logic unused_fmt;
  assign f64 = 1'b1;
  assign unused_fmt = in_fmt;
`endif
  logic [10:0] emax;
  logic [63:0] num [2];
  operand_t op [2];
  assign emax = f64 ? EMAX64 : EMAX32;
  assign num[0] = in_numA;
  assign num[1] = in_numB;
  // Decode both operands into a common binary64-shaped form; binary32 fraction sits left-justified
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      op[i].sign = num[i][63];
      op[i].exp = num[i][62:52];
      op[i].mant = {1'b1, num[i][51:0]};
`ifdef FP_ADDSUB_FMT32_EN
      if (!f64) begin
        op[i].sign = num[i][31];
        op[i].exp = {3'b0, num[i][30:23]};
        op[i].mant = {1'b1, num[i][22:0], {PAD32{1'b0}}};
      end
`endif
      op[i].is_zero = op[i].exp == '0;
      op[i].is_inf = op[i].exp == emax && op[i].mant[51:0] == '0;
      op[i].is_nan = op[i].exp == emax && op[i].mant[51:0] != '0;
    end
    op[1].sign = op[1].sign ^ in_addsub;
  end
  logic swap, sub_eff, big_s, sh, lost, half, below, lsb, up;
  logic [10:0] big_e, sml_e, d;
  logic [52:0] big_m, sml_m, keep, inc;
  logic [55:0] ms, alg, nrm;
  logic [56:0] s;
  logic [5:0] lz;
  logic signed [12:0] ne, re;
  logic [53:0] rs;
  logic [51:0] rm;
  assign swap = {op[1].exp, op[1].mant} > {op[0].exp, op[0].mant};
  assign big_s = swap ? op[1].sign : op[0].sign;
  assign big_e = swap ? op[1].exp : op[0].exp;
  assign big_m = swap ? op[1].mant : op[0].mant;
  assign sml_e = swap ? op[0].exp : op[1].exp;
  assign sml_m = swap ? op[0].mant : op[1].mant;
  assign sub_eff = op[0].sign ^ op[1].sign;
  assign d = big_e - sml_e;
  assign ms = {sml_m, 3'b0};
  assign sh = d >= 11'd56;
  assign lost = sh ? |ms : |(ms & ~({56{1'b1}} << d));
  assign alg = (sh ? 56'd0 : ms >> d) | {55'd0, lost};
  assign s = sub_eff ? {1'b0, big_m, 3'b0} - {1'b0, alg} : {1'b0, big_m, 3'b0} + {1'b0, alg};
  fp_lzc u_lzc (.d(s[55:0]), .cnt(lz));
  assign nrm = s[56] ? {s[56:2], s[1] | s[0]} : s[55:0] << lz;
  assign ne = s[56] ? $signed({2'b0, big_e}) + 13'sd1 : $signed({2'b0, big_e}) - $signed({7'b0, lz});
  assign keep = f64 ? nrm[55:3] : {nrm[55:PAD32+3], {PAD32{1'b0}}};
  assign half = f64 ? nrm[2] : nrm[PAD32+2];
  assign below = f64 ? |nrm[1:0] : |nrm[PAD32+1:0];
  assign lsb = f64 ? nrm[3] : nrm[PAD32+3];
  assign up = half & (below | lsb);
  assign inc = f64 ? 53'd1 : 53'd1 << PAD32;
  assign rs = {1'b0, keep} + (up ? {1'b0, inc} : 54'd0);
  assign rm = rs[53] ? rs[52:1] : rs[51:0];
  assign re = ne + $signed({12'd0, rs[53]});
  logic res_s, nan, of, uf;
  logic [10:0] res_e;
  logic [51:0] res_m;
  logic [63:0] pk;
  // Special operands take priority; otherwise range-check the rounded datapath result
  always_comb begin
    res_s = big_s;
    res_e = re[10:0];
    res_m = rm;
    nan = 1'b0;
    of = 1'b0;
    uf = 1'b0;
    if (op[0].is_nan || op[1].is_nan || (op[0].is_inf && op[1].is_inf && sub_eff)) nan = 1'b1;
    else if (op[0].is_inf || op[1].is_inf) begin
      res_s = op[0].is_inf ? op[0].sign : op[1].sign;
      res_e = emax;
      res_m = '0;
    end else if (op[0].is_zero && op[1].is_zero) begin
      res_s = op[0].sign & op[1].sign;
      res_e = '0;
      res_m = '0;
    end else if (op[0].is_zero || op[1].is_zero) begin
      res_s = op[0].is_zero ? op[1].sign : op[0].sign;
      res_e = op[0].is_zero ? op[1].exp : op[0].exp;
      res_m = op[0].is_zero ? op[1].mant[51:0] : op[0].mant[51:0];
    end else if (s == '0) begin
      res_s = 1'b0;
      res_e = '0;
      res_m = '0;
    end else if (re >= $signed({2'b0, emax})) begin
      res_e = emax;
      res_m = '0;
      of = 1'b1;
    end else if (re < 13'sd1) begin
      res_e = '0;
      res_m = '0;
      uf = 1'b1;
    end
  end
`ifdef FP_ADDSUB_FMT32_EN
  assign pk = f64 ? {res_s, res_e, res_m} : {32'd0, res_s, res_e[7:0], res_m[51:PAD32]};
`else
  assign pk = {res_s, res_e, res_m};
`endif
  // Register result and flags once; reset discards any in-flight operation
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_result <= '0;
      out_flag_OF <= 1'b0;
      out_flag_UF <= 1'b0;
    end else begin
      out_result <= nan ? (f64 ? QNAN64 : QNAN32) : pk;
      out_flag_OF <= of;
      out_flag_UF <= uf;
    end
  end
endmodule

// File: tb/tb_fp_add_sub.sv
// tb_fp_add_sub: table-driven scoreboard bench for fp_add_sub plus reset sequence
module tb_fp_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] a = '0, b = '0;
  logic addsub = 1'b0, fmt = 1'b1;
  logic [63:0] result;
  logic of, uf;
  fp_add_sub dut (
    .in_clk(clk), .in_rst(rst), .in_numA(a), .in_numB(b), .in_addsub(addsub), .in_fmt(fmt),
    .out_result(result), .out_flag_OF(of), .out_flag_UF(uf)
  );
  always #5 clk = ~clk;
`ifdef FP_ADDSUB_FMT32_EN
  localparam bit F32 = 1'b1;
`else
  localparam bit F32 = 1'b0;
`endif
  typedef struct {
    string name;
    logic [63:0] a, b;
    logic sub, fmt;
    logic [63:0] r;
    logic of, uf;
  } vec_t;
  typedef struct {
    string name;
    logic [63:0] r;
    logic of, uf;
  } exp_t;
  vec_t tv[$];
  exp_t sb[$];
  int errors = 0, checks = 0;
  task automatic chk(input string n, input logic [63:0] r, input logic o, input logic u);
    checks++;
    if (result !== r || of !== o || uf !== u) begin
      errors++;
      $display("FAIL %s: got result=%h OF=%b UF=%b, want result=%h OF=%b UF=%b", n, result, of, uf, r, o, u);
    end
  endtask
  task automatic add_v(input string n, input logic [63:0] va, input logic [63:0] vb, input logic vs,
                       input logic vf, input logic [63:0] vr, input logic vo, input logic vu);
    vec_t v;
    v.name = n; v.a = va; v.b = vb; v.sub = vs; v.fmt = vf; v.r = vr; v.of = vo; v.uf = vu;
    tv.push_back(v);
  endtask
  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk(e.name, e.r, e.of, e.uf);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t e;
    add_v("add_1_2", 64'h3FF0000000000000, 64'h4000000000000000, 0, 1, 64'h4008000000000000, 0, 0);
    add_v("sub_1_2", 64'h3FF0000000000000, 64'h4000000000000000, 1, 1, 64'hBFF0000000000000, 0, 0);
    add_v("sub_equal", 64'h3FF0000000000000, 64'h3FF0000000000000, 1, 1, 64'h0, 0, 0);
    add_v("ovf_max", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 1, 64'h7FF0000000000000, 1, 0);
    add_v("inf_minus_inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 1, 1, 64'h7FF8000000000000, 0, 0);
    add_v("uf_sub", 64'h0010000000000001, 64'h0010000000000000, 1, 1, 64'h0, 0, 1);
    add_v("f32_add_upper", 64'hFFFFFFFF3F800000, 64'h0000000040000000, 0, 0,
          F32 ? 64'h0000000040400000 : 64'h7FF8000000000000, 0, 0);
    add_v("nan_in", 64'h7FF0000000000001, 64'h3FF0000000000000, 0, 1, 64'h7FF8000000000000, 0, 0);
    add_v("inf_plus_1", 64'h7FF0000000000000, 64'h3FF0000000000000, 0, 1, 64'h7FF0000000000000, 0, 0);
    add_v("1_minus_inf", 64'h3FF0000000000000, 64'h7FF0000000000000, 1, 1, 64'hFFF0000000000000, 0, 0);
    add_v("neg0_neg0", 64'h8000000000000000, 64'h8000000000000000, 0, 1, 64'h8000000000000000, 0, 0);
    add_v("pos0_neg0", 64'h0, 64'h8000000000000000, 0, 1, 64'h0, 0, 0);
    add_v("zero_minus_1", 64'h0, 64'h3FF0000000000000, 1, 1, 64'hBFF0000000000000, 0, 0);
    add_v("subnorm_flush", 64'h0000000000000001, 64'h3FF0000000000000, 0, 1, 64'h3FF0000000000000, 0, 0);
    add_v("tie_even", 64'h3FF0000000000000, 64'h3CA0000000000000, 0, 1, 64'h3FF0000000000000, 0, 0);
    add_v("tie_odd", 64'h3FF0000000000001, 64'h3CA0000000000000, 0, 1, 64'h3FF0000000000002, 0, 0);
    add_v("above_half", 64'h3FF0000000000000, 64'h3CA0000000000001, 0, 1, 64'h3FF0000000000001, 0, 0);
    add_v("far_add", 64'h3FF0000000000000, 64'h39B0000000000000, 0, 1, 64'h3FF0000000000000, 0, 0);
    add_v("far_sub", 64'h3FF0000000000000, 64'h39B0000000000000, 1, 1, 64'h3FF0000000000000, 0, 0);
    add_v("2_minus_1p5", 64'h4000000000000000, 64'h3FF8000000000000, 1, 1, 64'h3FE0000000000000, 0, 0);
    add_v("f32_sub", 64'h3FC00000, 64'h40000000, 1, 0, F32 ? 64'hBF000000 : 64'h0, 0, 0);
    add_v("f32_ovf", 64'h7F7FFFFF, 64'h7F7FFFFF, 0, 0, F32 ? 64'h7F800000 : 64'h0, F32, 0);
    add_v("f32_inf_inf", 64'h7F800000, 64'h7F800000, 1, 0, F32 ? 64'h7FC00000 : 64'h0, 0, 0);
    add_v("f32_uf", 64'h00800001, 64'h00800000, 1, 0, 64'h0, 0, F32);
    add_v("f32_tie_odd", 64'h3F800001, 64'h33800000, 0, 0, F32 ? 64'h3F800002 : 64'h0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_state", 64'h0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      pop_chk();
      a = tv[i].a;
      b = tv[i].b;
      addsub = tv[i].sub;
      fmt = tv[i].fmt;
      e.name = tv[i].name; e.r = tv[i].r; e.of = tv[i].of; e.uf = tv[i].uf;
      sb.push_back(e);
    end
    @(negedge clk);
    pop_chk();
    a = 64'h3FF0000000000000;
    b = 64'h4000000000000000;
    addsub = 1'b0;
    fmt = 1'b1;
    @(posedge clk);
    #1 chk("pre_reset", 64'h4008000000000000, 0, 0);
    #2 rst = 1'b1;
    #1 chk("async_reset", 64'h0, 0, 0);
    @(negedge clk);
    addsub = 1'b1;
    @(posedge clk);
    #1 chk("reset_hold", 64'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_release", 64'h0, 0, 0);
    @(posedge clk);
    #1 chk("first_after_reset", 64'hBFF0000000000000, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
